// File: rtl/sev_seg_capture.sv
// Capture side of the multiplexed seven-segment display: debounces each digit dwell,
// decodes it back to hex and publishes whole four-digit frames. Optional watchdog: SEVSEG_CAP_TIMEOUT_EN.
module sev_seg_capture #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] segEn,
    input  logic [6:0] seg,
    output logic [3:0] disp3,
    output logic [3:0] disp2,
    output logic [3:0] disp1,
    output logic [3:0] disp0,
    output logic       frameValid,
    output logic [3:0] digitSeen,
    output logic       decodeErr,
    output logic       enErr,
    output logic       stale
);

    localparam int unsigned SMP_W = 11;
    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("sev_seg_capture: illegal STABLE_CYCLES or TIMEOUT_CYCLES");
    end

    logic [SMP_W-1:0] smp_q, smp_d;
    logic [CNT_W-1:0] st_cnt_q, st_cnt_d;
    logic [3:0][3:0]  shadow_q, shadow_d;
    logic [3:0][3:0]  disp_q, disp_d;
    logic [3:0]       seen_q, seen_d;
    logic             frame_q, frame_d;
    logic             dec_err_q, dec_err_d;
    logic             en_err_q, en_err_d;

    logic             ripe_c, capture_c, to_c;
    logic             glyph_ok_c, onehot_c, multi_c;
    logic [3:0]       en_c, nib_c;

    // Active-low glyph to {legal, nibble}
    function automatic logic [4:0] glyph_decode(input logic [6:0] s);
        logic [4:0] r;
        r = 5'h00;
        case (s)
            7'h40: r = {1'b1, 4'h0};
            7'h79: r = {1'b1, 4'h1};
            7'h24: r = {1'b1, 4'h2};
            7'h30: r = {1'b1, 4'h3};
            7'h19: r = {1'b1, 4'h4};
            7'h12: r = {1'b1, 4'h5};
            7'h02: r = {1'b1, 4'h6};
            7'h78: r = {1'b1, 4'h7};
            7'h00: r = {1'b1, 4'h8};
            7'h10: r = {1'b1, 4'h9};
            7'h08: r = {1'b1, 4'hA};
            7'h03: r = {1'b1, 4'hB};
            7'h46: r = {1'b1, 4'hC};
            7'h21: r = {1'b1, 4'hD};
            7'h06: r = {1'b1, 4'hE};
            7'h0E: r = {1'b1, 4'hF};
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // The incoming sample is compared against the held one so a dwell ripens on its Nth sample edge
    always_comb begin
        smp_d    = {segEn, seg};
        st_cnt_d = st_cnt_q;
        if (smp_d != smp_q) begin
            st_cnt_d = CNT_W'(1);
        end else if (st_cnt_q != CNT_W'(STABLE_CYCLES)) begin
            st_cnt_d = st_cnt_q + CNT_W'(1);
        end
        ripe_c = (st_cnt_d == CNT_W'(STABLE_CYCLES)) && (st_cnt_q != CNT_W'(STABLE_CYCLES));

        en_c                 = ~smp_d[10:7];
        {glyph_ok_c, nib_c}  = glyph_decode(smp_d[6:0]);
        multi_c              = (en_c & (en_c - 4'd1)) != 4'd0;
        onehot_c             = (en_c != 4'd0) && !multi_c;

        capture_c = ripe_c && onehot_c && glyph_ok_c;
        dec_err_d = ripe_c && onehot_c && !glyph_ok_c;
        en_err_d  = ripe_c && multi_c;

        frame_d  = (seen_q == 4'hF);
        disp_d   = frame_d ? shadow_q : disp_q;
        seen_d   = (frame_d || to_c) ? 4'h0 : seen_q;
        shadow_d = shadow_q;
        if (capture_c) begin
            seen_d = seen_d | en_c;
            for (int k = 0; k < 4; k++) begin
                if (en_c[k]) begin
                    shadow_d[k] = nib_c;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_q     <= '0;
            st_cnt_q  <= '0;
            shadow_q  <= '0;
            disp_q    <= '0;
            seen_q    <= '0;
            frame_q   <= 1'b0;
            dec_err_q <= 1'b0;
            en_err_q  <= 1'b0;
        end else begin
            smp_q     <= smp_d;
            st_cnt_q  <= st_cnt_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            seen_q    <= seen_d;
            frame_q   <= frame_d;
            dec_err_q <= dec_err_d;
            en_err_q  <= en_err_d;
        end
    end

`ifdef SEVSEG_CAP_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            stale_q, stale_d;

    // Watchdog: a capture always wins over an expiry landing on the same edge
    always_comb begin
        to_c = 1'b0;
        wd_d = wd_q;
        if (capture_c) begin
            wd_d = '0;
        end else if (wd_q >= WD_W'(TIMEOUT_CYCLES - 1)) begin
            to_c = 1'b1;
            wd_d = '0;
        end else begin
            wd_d = wd_q + WD_W'(1);
        end
        stale_d = stale_q;
        if (frame_d) begin
            stale_d = 1'b0;
        end else if (to_c) begin
            stale_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q    <= '0;
            stale_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            stale_q <= stale_d;
        end
    end

    assign stale = stale_q;
`else
    assign to_c  = 1'b0;
    assign stale = 1'b0;
`endif

    assign disp3      = disp_q[3];
    assign disp2      = disp_q[2];
    assign disp1      = disp_q[1];
    assign disp0      = disp_q[0];
    assign frameValid = frame_q;
    assign digitSeen  = seen_q;
    assign decodeErr  = dec_err_q;
    assign enErr      = en_err_q;

endmodule

// File: tb/tb_sev_seg_capture.sv
// Directed bench for sev_seg_capture with hand-computed expectations (STABLE_CYCLES=4, TIMEOUT_CYCLES=16).
module tb_sev_seg_capture;

    localparam logic [3:0] BLANK = 4'hF;
    localparam logic [6:0] OFF   = 7'h7F;

    logic       clk;
    logic       rst;
    logic [3:0] segEn;
    logic [6:0] seg;
    logic [3:0] disp3, disp2, disp1, disp0;
    logic       frameValid;
    logic [3:0] digitSeen;
    logic       decodeErr;
    logic       enErr;
    logic       stale;

    int total  = 0;
    int bad    = 0;
    int fv_cnt = 0;
    int de_cnt = 0;
    int ee_cnt = 0;

    sev_seg_capture #(
        .STABLE_CYCLES (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .segEn     (segEn),
        .seg       (seg),
        .disp3     (disp3),
        .disp2     (disp2),
        .disp1     (disp1),
        .disp0     (disp0),
        .frameValid(frameValid),
        .digitSeen (digitSeen),
        .decodeErr (decodeErr),
        .enErr     (enErr),
        .stale     (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (frameValid) fv_cnt++;
            if (decodeErr)  de_cnt++;
            if (enErr)      ee_cnt++;
        end
    end

    // Present one pattern for n sampling edges, then settle 1ns past the last edge
    task automatic drive(input logic [3:0] en, input logic [6:0] s, input int n);
        @(negedge clk);
        segEn = en;
        seg   = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        segEn = BLANK;
        seg   = OFF;
        #2 rst = 1'b1;
        #1;
        total++; if (digitSeen !== 4'h0) begin bad++; $display("FAIL por_digitSeen: got %h want 0", digitSeen); end
        @(negedge clk) rst = 1'b0;
        drive(BLANK, OFF, 2);
        drive(4'b1110, 7'h40, 8);
        drive(4'b1101, 7'h79, 8);
        total++; if (digitSeen !== 4'b0011) begin bad++; $display("FAIL pre_reset_seen: got %b want 0011", digitSeen); end
        drive(4'b1011, 7'h24, 2);
        #2 rst = 1'b1;
        #1;
        total++; if (digitSeen !== 4'h0) begin bad++; $display("FAIL async_reset_seen: got %b want 0000", digitSeen); end
        total++; if ({disp3, disp2, disp1, disp0} !== 16'h0) begin bad++; $display("FAIL async_reset_disp: got %h want 0000", {disp3, disp2, disp1, disp0}); end
        total++; if ({frameValid, decodeErr, enErr, stale} !== 4'b0) begin bad++; $display("FAIL async_reset_flags: got %b want 0000", {frameValid, decodeErr, enErr, stale}); end
        @(negedge clk);
        segEn = BLANK;
        seg   = OFF;
        rst   = 1'b0;
    endtask

    task automatic test_normal_frame();
        int fv0;
        fv0 = fv_cnt;
        drive(BLANK, OFF, 2);
        drive(4'b0111, 7'h30, 8);
        drive(4'b1011, 7'h24, 8);
        drive(4'b1101, 7'h79, 8);
        drive(4'b1110, 7'h40, 4);
        total++; if (digitSeen !== 4'hF) begin bad++; $display("FAIL frame_all_seen: got %b want 1111", digitSeen); end
        total++; if (frameValid !== 1'b0) begin bad++; $display("FAIL frame_early: got %b want 0", frameValid); end
        drive(4'b1110, 7'h40, 1);
        total++; if (frameValid !== 1'b1) begin bad++; $display("FAIL frame_pulse: got %b want 1", frameValid); end
        total++; if ({disp3, disp2, disp1, disp0} !== 16'h3210) begin bad++; $display("FAIL frame_disp: got %h want 3210", {disp3, disp2, disp1, disp0}); end
        total++; if (digitSeen !== 4'h0) begin bad++; $display("FAIL frame_seen_clear: got %b want 0000", digitSeen); end
        drive(4'b1110, 7'h40, 3);
        total++; if (fv_cnt - fv0 !== 1) begin bad++; $display("FAIL frame_count: got %0d want 1", fv_cnt - fv0); end
        total++; if (digitSeen !== 4'h0) begin bad++; $display("FAIL frame_no_recapture: got %b want 0000", digitSeen); end
    endtask

    task automatic test_short_dwell();
        int de0, ee0;
        de0 = de_cnt;
        ee0 = ee_cnt;
        drive(BLANK, OFF, 2);
        drive(4'b1011, 7'h24, 3);
        total++; if (digitSeen !== 4'h0) begin bad++; $display("FAIL short_3_samples: got %b want 0000", digitSeen); end
        drive(BLANK, OFF, 2);
        total++; if (digitSeen !== 4'h0) begin bad++; $display("FAIL short_ignored: got %b want 0000", digitSeen); end
        total++; if ((de_cnt - de0) + (ee_cnt - ee0) !== 0) begin bad++; $display("FAIL short_no_err: got %0d want 0", (de_cnt - de0) + (ee_cnt - ee0)); end
        drive(4'b1011, 7'h24, 3);
        total++; if (digitSeen !== 4'h0) begin bad++; $display("FAIL latency_early: got %b want 0000", digitSeen); end
        drive(4'b1011, 7'h24, 1);
        total++; if (digitSeen !== 4'b0100) begin bad++; $display("FAIL latency_capture: got %b want 0100", digitSeen); end
        drive(BLANK, OFF, 1);
    endtask

    task automatic test_bad_inputs();
        int de0, ee0;
        de0 = de_cnt;
        ee0 = ee_cnt;
        drive(4'b1110, 7'h7F, 4);
        total++; if (decodeErr !== 1'b1) begin bad++; $display("FAIL decode_err_edge: got %b want 1", decodeErr); end
        drive(4'b1110, 7'h7F, 4);
        total++; if (de_cnt - de0 !== 1) begin bad++; $display("FAIL decode_err_count: got %0d want 1", de_cnt - de0); end
        total++; if (digitSeen[0] !== 1'b0) begin bad++; $display("FAIL decode_err_seen0: got %b want 0", digitSeen[0]); end
        drive(BLANK, OFF, 2);
        drive(4'b1100, 7'h40, 8);
        total++; if (ee_cnt - ee0 !== 1) begin bad++; $display("FAIL en_err_count: got %0d want 1", ee_cnt - ee0); end
        total++; if (de_cnt - de0 !== 1) begin bad++; $display("FAIL en_err_no_decode: got %0d want 1", de_cnt - de0); end
        total++; if (digitSeen[1:0] !== 2'b00) begin bad++; $display("FAIL en_err_no_capture: got %b want 00", digitSeen[1:0]); end
        drive(BLANK, OFF, 2);
    endtask

    task automatic test_overwrite();
        int fv0;
        fv0 = fv_cnt;
        drive(4'b1110, 7'h12, 8);
        total++; if (digitSeen[0] !== 1'b1) begin bad++; $display("FAIL overwrite_first: got %b want 1", digitSeen[0]); end
        drive(BLANK, OFF, 2);
        drive(4'b1110, 7'h08, 8);
        drive(4'b0111, 7'h06, 8);
        drive(4'b1011, 7'h46, 8);
        drive(4'b1101, 7'h21, 8);
        total++; if (fv_cnt - fv0 !== 1) begin bad++; $display("FAIL overwrite_frames: got %0d want 1", fv_cnt - fv0); end
        total++; if ({disp3, disp2, disp1, disp0} !== 16'hECDA) begin bad++; $display("FAIL overwrite_disp: got %h want ecda", {disp3, disp2, disp1, disp0}); end
        total++; if (digitSeen !== 4'h0) begin bad++; $display("FAIL overwrite_seen: got %b want 0000", digitSeen); end
    endtask

    task automatic test_timeout();
`ifdef SEVSEG_CAP_TIMEOUT_EN
        int fv0;
        total++; if (stale !== 1'b0) begin bad++; $display("FAIL timeout_start_stale: got %b want 0", stale); end
        drive(4'b1110, 7'h40, 4);
        drive(4'b1101, 7'h79, 4);
        drive(BLANK, OFF, 15);
        total++; if (digitSeen !== 4'b0011) begin bad++; $display("FAIL timeout_early_seen: got %b want 0011", digitSeen); end
        total++; if (stale !== 1'b0) begin bad++; $display("FAIL timeout_early_stale: got %b want 0", stale); end
        drive(BLANK, OFF, 1);
        total++; if (digitSeen !== 4'h0) begin bad++; $display("FAIL timeout_seen: got %b want 0000", digitSeen); end
        total++; if (stale !== 1'b1) begin bad++; $display("FAIL timeout_stale: got %b want 1", stale); end
        fv0 = fv_cnt;
        drive(4'b0111, 7'h19, 8);
        drive(4'b1011, 7'h02, 8);
        drive(4'b1101, 7'h78, 8);
        drive(4'b1110, 7'h10, 8);
        total++; if (fv_cnt - fv0 !== 1) begin bad++; $display("FAIL timeout_frame: got %0d want 1", fv_cnt - fv0); end
        total++; if ({disp3, disp2, disp1, disp0} !== 16'h4679) begin bad++; $display("FAIL timeout_disp: got %h want 4679", {disp3, disp2, disp1, disp0}); end
        total++; if (stale !== 1'b0) begin bad++; $display("FAIL stale_cleared: got %b want 0", stale); end
`else
        drive(4'b1110, 7'h40, 4);
        drive(4'b1101, 7'h79, 4);
        drive(BLANK, OFF, 40);
        total++; if (digitSeen !== 4'b0011) begin bad++; $display("FAIL partial_persists: got %b want 0011", digitSeen); end
        total++; if (stale !== 1'b0) begin bad++; $display("FAIL stale_tied: got %b want 0", stale); end
`endif
    endtask

    initial begin
        test_reset();
        test_normal_frame();
        test_short_dwell();
        test_bad_inputs();
        test_overwrite();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
